// File: rtl/fifo_drain_stream.sv
// Read-side drain stage: issues credit-limited FIFO reads, absorbs the one-cycle read
// latency in a 2-entry skid buffer and emits a framed valid/ready stream.
// Optional FIFO_DRAIN_STATS_EN adds word_cnt / stall statistics outputs.
module fifo_drain_stream #(
  parameter int FIFO_WIDTH = 32,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [31:0]           word_cnt,
  output logic                  stall
`endif
);

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic [1:0]            occ;
  logic                  vld_p1;
  logic                  head;
  logic                  tail;
  logic [FIFO_WIDTH-1:0] mem [2];
  logic [15:0]           beat;

  logic                  pop;
  logic                  issue;
  logic [1:0]            occ_nxt;
  logic [15:0]           beat_nxt;

  // Issue stage: a read is allowed only while buffer + in-flight stays within 2 slots
  always_comb begin
    pop      = m_valid & m_ready;
    issue    = rst_n & enable & ~fifo_empty &
               (({1'b0, occ} + {2'b0, vld_p1}) < (3'd2 + {2'b0, pop}));
    occ_nxt  = occ + {1'b0, vld_p1} - {1'b0, pop};
    beat_nxt = beat;
    if (pop) begin
      beat_nxt = (beat == LAST_BEAT) ? 16'd0 : beat + 16'd1;
    end
  end

  assign fifo_rd_en = issue;

  // Capture stage: FIFO word lands one edge after the read was accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      occ     <= 2'd0;
      head    <= 1'b0;
      tail    <= 1'b0;
      beat    <= 16'd0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      vld_p1  <= issue;
      occ     <= occ_nxt;
      tail    <= tail ^ vld_p1;
      head    <= head ^ pop;
      beat    <= beat_nxt;
      m_valid <= (occ_nxt != 2'd0);
      m_last  <= (occ_nxt != 2'd0) && (beat_nxt == LAST_BEAT);
      // The output register mirrors whichever entry becomes head after this edge
      if (vld_p1 && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
        m_data <= fifo_data;
      end else if (pop && (occ == 2'd2)) begin
        m_data <= mem[~head];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      mem[tail] <= fifo_data;
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= 32'd0;
      stall    <= 1'b0;
    end else begin
      stall <= m_valid & ~m_ready;
      if (pop && (word_cnt != 32'hFFFF_FFFF)) begin
        word_cnt <= word_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
